// File: rtl/gpio_in_port.sv
// gpio_in_port: synchronised, debounced single GPIO input with sticky
// rise/fall event flags, a wrapping rising-edge counter and an interrupt.
// The raw pin goes through two flops; a four-state FSM then requires
// DEBOUNCE consecutive samples of the opposite level before committing.
module gpio_in_port #(
  parameter int DEBOUNCE = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       GPIO,
  input  logic       eventClr,
  output logic       dataOut,
  output logic       riseFlag,
  output logic       fallFlag,
  output logic [7:0] riseCount,
  output logic       irq
);

  // Counter width: enough to hold DEBOUNCE-1, never narrower than one bit.
  localparam int CW = (DEBOUNCE <= 2) ? 1 : $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

  logic          sync1_r;
  logic          sync2_r;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          commit_rise_s;
  logic          commit_fall_s;
  logic          data_r;
  logic          data_nxt_s;
  logic          rise_flag_r;
  logic          rise_flag_nxt_s;
  logic          fall_flag_r;
  logic          fall_flag_nxt_s;
  logic [7:0]    rise_cnt_r;
  logic [7:0]    rise_cnt_nxt_s;

  // Two-flop synchroniser for the asynchronous pin; only sync2_r is used.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= GPIO;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM state and run-length counter registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= STABLE_LO;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: count consecutive opposite samples, abort on any
  // return to the stable level, commit on the DEBOUNCE-th sample.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    commit_rise_s = 1'b0;
    commit_fall_s = 1'b0;
    case (state_r)
      STABLE_LO: begin
        if (sync2_r) begin
          state_nxt_s = CHECK_HI;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = STABLE_LO;
        end
      end
      CHECK_HI: begin
        if (!sync2_r) begin
          state_nxt_s = STABLE_LO;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s   = STABLE_HI;
          cnt_nxt_s     = CNT_ZERO;
          commit_rise_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync2_r) begin
          state_nxt_s = CHECK_LO;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = STABLE_HI;
        end
      end
      CHECK_LO: begin
        if (sync2_r) begin
          state_nxt_s = STABLE_HI;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s   = STABLE_LO;
          cnt_nxt_s     = CNT_ZERO;
          commit_fall_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = STABLE_LO;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Event bookkeeping: a commit sets its own flag even when eventClr
  // arrives on the same edge; the counter restarts at 1 in that case.
  always_comb begin
    data_nxt_s      = data_r;
    rise_flag_nxt_s = rise_flag_r;
    fall_flag_nxt_s = fall_flag_r;
    rise_cnt_nxt_s  = rise_cnt_r;
    if (commit_rise_s) begin
      data_nxt_s      = 1'b1;
      rise_flag_nxt_s = 1'b1;
      if (eventClr) begin
        fall_flag_nxt_s = 1'b0;
        rise_cnt_nxt_s  = 8'd1;
      end else begin
        rise_cnt_nxt_s  = rise_cnt_r + 8'd1;
      end
    end else if (commit_fall_s) begin
      data_nxt_s      = 1'b0;
      fall_flag_nxt_s = 1'b1;
      if (eventClr) begin
        rise_flag_nxt_s = 1'b0;
        rise_cnt_nxt_s  = 8'd0;
      end else begin
        rise_flag_nxt_s = rise_flag_r;
      end
    end else if (eventClr) begin
      rise_flag_nxt_s = 1'b0;
      fall_flag_nxt_s = 1'b0;
      rise_cnt_nxt_s  = 8'd0;
    end else begin
      data_nxt_s = data_r;
    end
  end

  // Registered debounced level, sticky flags and rise counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      data_r      <= 1'b0;
      rise_flag_r <= 1'b0;
      fall_flag_r <= 1'b0;
      rise_cnt_r  <= 8'd0;
    end else begin
      data_r      <= data_nxt_s;
      rise_flag_r <= rise_flag_nxt_s;
      fall_flag_r <= fall_flag_nxt_s;
      rise_cnt_r  <= rise_cnt_nxt_s;
    end
  end

  assign dataOut   = data_r;
  assign riseFlag  = rise_flag_r;
  assign fallFlag  = fall_flag_r;
  assign riseCount = rise_cnt_r;
  assign irq       = rise_flag_r | fall_flag_r;

endmodule

// File: tb/tb_gpio_in_port.sv
// Testbench for gpio_in_port: a sliding-window reference model (the last
// DEBOUNCE synchronised samples all differ from the level -> flip) checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_gpio_in_port;

  localparam int DB = 4;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       GPIO = 1'b0;
  logic       eventClr = 1'b0;
  logic       dataOut;
  logic       riseFlag;
  logic       fallFlag;
  logic [7:0] riseCount;
  logic       irq;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  gpio_in_port #(.DEBOUNCE(DB)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .GPIO(GPIO), .eventClr(eventClr),
    .dataOut(dataOut), .riseFlag(riseFlag), .fallFlag(fallFlag),
    .riseCount(riseCount), .irq(irq)
  );

  // Free-running clock, period 10.
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reference model state.
  logic       m_level = 1'b0;
  logic       m_rise = 1'b0;
  logic       m_fall = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic       dly[$];
  logic       win[$];

  // Model: pin seen two edges late; flip when the whole window disagrees.
  always @(posedge CLK or negedge RESET_N) begin : model_p
    logic fed;
    bit   all_diff;
    if (!RESET_N) begin
      m_level = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_cnt   = 8'd0;
      dly     = '{1'b0, 1'b0};
      win.delete();
    end else begin
      fed = dly[1];
      dly.push_front(GPIO);
      void'(dly.pop_back());
      win.push_back(fed);
      if (win.size() > DB) void'(win.pop_front());
      all_diff = (win.size() == DB);
      foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        if (m_level) begin
          m_rise = 1'b1;
          m_cnt  = eventClr ? 8'd1 : m_cnt + 8'd1;
          if (eventClr) m_fall = 1'b0;
        end else begin
          m_fall = 1'b1;
          if (eventClr) begin
            m_rise = 1'b0;
            m_cnt  = 8'd0;
          end
        end
      end else if (eventClr) begin
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_cnt  = 8'd0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("cyc_dataOut", {31'd0, dataOut}, {31'd0, m_level});
      chk("cyc_riseFlag", {31'd0, riseFlag}, {31'd0, m_rise});
      chk("cyc_fallFlag", {31'd0, fallFlag}, {31'd0, m_fall});
      chk("cyc_riseCount", {24'd0, riseCount}, {24'd0, m_cnt});
      chk("cyc_irq", {31'd0, irq}, {31'd0, m_rise | m_fall});
    end
  end

  task automatic chk_all(input string name, input logic d, input logic r,
                         input logic f, input logic [7:0] c);
    chk({name, "_dataOut"}, {31'd0, dataOut}, {31'd0, d});
    chk({name, "_riseFlag"}, {31'd0, riseFlag}, {31'd0, r});
    chk({name, "_fallFlag"}, {31'd0, fallFlag}, {31'd0, f});
    chk({name, "_riseCount"}, {24'd0, riseCount}, {24'd0, c});
    chk({name, "_irq"}, {31'd0, irq}, {31'd0, r | f});
  endtask

  initial begin
    tick(3);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    #2 RESET_N = 1'b1;
    cmp_en = 1'b1;
    tick(3);

    // Clean rise: first sampled at edge t, committed at edge t+5.
    GPIO = 1'b1;
    tick(5);
    chk_all("rise_t4", 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_all("rise_t5", 1'b1, 1'b1, 1'b0, 8'd1);

    // Fall from stable high, then clear.
    GPIO = 1'b0;
    tick(5);
    chk_all("fall_t4", 1'b1, 1'b1, 1'b0, 8'd1);
    tick(1);
    chk_all("fall_t5", 1'b0, 1'b1, 1'b1, 8'd1);
    eventClr = 1'b1;
    tick(1);
    eventClr = 1'b0;
    chk_all("clear", 1'b0, 1'b0, 1'b0, 8'd0);

    // Glitches of 3 samples never commit.
    for (int g = 0; g < 5; g++) begin
      GPIO = 1'b1;
      tick(3);
      GPIO = 1'b0;
      tick(4);
    end
    tick(4);
    chk_all("glitch", 1'b0, 1'b0, 1'b0, 8'd0);

    // 256 rises wrap the counter to 0; the 257th gives 1.
    for (int k = 0; k < 256; k++) begin
      GPIO = 1'b1;
      tick(6);
      GPIO = 1'b0;
      tick(6);
    end
    chk_all("wrap256", 1'b0, 1'b1, 1'b1, 8'd0);
    GPIO = 1'b1;
    tick(6);
    chk_all("wrap257", 1'b1, 1'b1, 1'b1, 8'd1);

    // eventClr on the exact rise-commit edge.
    GPIO = 1'b0;
    tick(6);
    chk_all("pre_coinc", 1'b0, 1'b1, 1'b1, 8'd1);
    GPIO = 1'b1;
    tick(5);
    eventClr = 1'b1;
    tick(1);
    eventClr = 1'b0;
    chk_all("coinc", 1'b1, 1'b1, 1'b0, 8'd1);

    // Reset mid-check (cnt=2): outputs clear at once, commit after release.
    GPIO = 1'b0;
    tick(6);
    chk_all("pre_rst", 1'b0, 1'b1, 1'b1, 8'd1);
    GPIO = 1'b1;
    tick(4);
    RESET_N = 1'b0;
    #1;
    chk_all("rst_now", 1'b0, 1'b0, 1'b0, 8'd0);
    #10 RESET_N = 1'b1;
    tick(5);
    chk_all("rel_t4", 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_all("rel_t5", 1'b1, 1'b1, 1'b0, 8'd1);

    // Randomised bouncing pin with occasional clears.
    for (int b = 0; b < 400; b++) begin
      int hold;
      GPIO = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 2 * DB + 1);
      for (int h = 0; h < hold; h++) begin
        eventClr = ($urandom_range(0, 15) == 0);
        tick(1);
      end
      eventClr = 1'b0;
    end
    tick(2);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
